fx2_reg_cmd_parser: RTL
=======================

Name: fx2_reg_cmd_parser

Overview:
- Command-side stage directly upstream of the timetagger register file.
- Consumes the host byte stream drained from the FX2 OUT endpoint and frames 8-byte register commands: 0xAA, write flag, addr[7:0], addr[15:8], value[7:0] through value[31:24].
- Issues one register-bus transaction per frame.
- Returns the 32-bit register readback as a 4-byte reply stream toward the FX2 IN endpoint arbiter.

Parameters:
- RD_LATENCY, 1: cycles from the reg_rd pulse to reg_rdata being valid (1..7).
- TIMEOUT, 4096: maximum idle cycles between bytes inside a frame before the frame is aborted; 0 disables the timeout.
- SYNC_BYTE, 8'hAA: frame start marker.

Ports:
- clk  in  1  system clock (FX2 interface clock domain).
- reset  in  1  synchronous, active-high reset.
- in_data  in  8  command byte from the OUT FIFO reader.
- in_valid  in  1  in_data holds a byte.
- in_ready  out  1  parser accepts the byte; transfer occurs when in_valid && in_ready.
- reg_addr  out  16  register address.
- reg_wdata  out  32  register write value.
- reg_wr  out  1  one-cycle write strobe.
- reg_rd  out  1  one-cycle read strobe.
- reg_rdata  in  32  readback, valid RD_LATENCY cycles after reg_rd.
- out_data  out  8  reply byte.
- out_valid  out  1  out_data holds a byte.
- out_ready  in  1  consumer takes the byte; transfer occurs when out_valid && out_ready.
- busy  out  1  high in every state except HUNT.
- frame_abort  out  1  one-cycle pulse when a frame is discarded.

Behaviour:
- Clocking and reset:
  - One clock. Reset is synchronous and active-high; the clock port is clk and the reset port is reset.
  - Reset values: state=HUNT, in_ready=1, reg_wr=0, reg_rd=0, out_valid=0, out_data=0, reg_addr=0, reg_wdata=0, busy=0, frame_abort=0.
  - Reset asserted mid-frame or mid-reply returns to HUNT on the next edge. A partially sent reply is dropped and no strobes are emitted.
- States: HUNT, FLAG, A0, A1, V0, V1, V2, V3, WRITE, READ, WAIT, R0, R1, R2, R3.
- Byte acceptance and parsing:
  - in_ready=1 in HUNT through V3; in_ready=0 in WRITE through R3.
  - HUNT: an accepted byte equal to SYNC_BYTE moves to FLAG. Any other byte is discarded silently; no frame_abort.
  - FLAG: byte 0x00 latches wr=0 and 0x01 latches wr=1, then moves to A0. Any other value causes abort: the byte is consumed, frame_abort pulses and the state returns to HUNT.
  - A0 and A1 load reg_addr low byte, then high byte.
  - V0 through V3 load reg_wdata little-endian. After the V3 byte is accepted: go to WRITE if wr=1, else READ.
- Register transaction:
  - WRITE: reg_wr=1 for exactly one cycle, with reg_addr and reg_wdata stable; next state READ.
  - READ: reg_rd=1 for exactly one cycle; reg_addr is held until the reply completes.
  - WAIT: count RD_LATENCY cycles from the reg_rd cycle, capture reg_rdata into the reply register, then go to R0.
  - Writes therefore also return readback.
  - Latency from last frame byte accepted to first out_valid: RD_LATENCY+2 cycles for a read, RD_LATENCY+3 for a write.
- Reply:
  - R0 through R3 present reply[7:0], [15:8], [23:16], [31:24] with out_valid=1.
  - out_data and out_valid hold until out_ready; each handshake advances one byte. A stalled out_ready holds indefinitely, with no timeout in reply states.
  - After the R3 handshake: out_valid=0, state HUNT, and in_ready=1 on the next cycle.
- Timeout:
  - In FLAG through V3, an idle counter clears on every accepted byte and increments otherwise.
  - On reaching TIMEOUT (TIMEOUT≠0): frame_abort pulses, state returns to HUNT, and no register strobe is emitted.
  - A byte presented on the same cycle the count reaches TIMEOUT is accepted; the timeout does not fire that cycle.
- Resynchronisation:
  - SYNC_BYTE appearing inside a frame is treated as data; there is no mid-frame resync.
  - Back-to-back frames are supported. The next frame's 0xAA is accepted in HUNT on the cycle after R3 completes.

Test Plan:
- Garbage then read: bytes FF FF FF, then frame AA 00 01 00 00 00 00 00 with reg_rdata=0x00000003 -> no frame_abort, no reg_wr; one reg_rd with reg_addr=0x0001; reply bytes 03 00 00 00.
- Write: frame AA 01 03 00 04 00 00 00 -> one reg_wr pulse with addr=0x0003, wdata=0x00000004, then one reg_rd; reply equals the modelled readback 04 00 00 00, LSB first.
- Bad flag: AA 02 ... -> frame_abort pulse after the 0x02 byte. A following valid frame AA 00 02 00 00 00 00 00 reads addr 0x0002 normally.
- Timeout with TIMEOUT=16: send AA 00 01, then idle 16 cycles -> frame_abort pulse, no strobes. A subsequent complete frame is processed correctly.
- Reply backpressure: out_ready held low 20 cycles during R1 -> out_data stays at byte 1 value, in_ready=0 throughout, and exactly 4 handshakes occur in total.
- Reset mid-op: assert reset in the WAIT state and again during R2 -> outputs return to reset values next edge, and no further reply bytes are emitted.

Source files
------------

// File: rtl/fx2_reg_cmd_parser.sv
// rtl/fx2_reg_cmd_parser.sv - FX2 host command framer driving the register bus and returning 4-byte readback
//
// Frames 8-byte commands (SYNC_BYTE, write flag, addr lo/hi, value LSB..MSB)
// from the OUT-endpoint byte stream, issues an optional write strobe followed
// by a read strobe, and streams the 32-bit readback LSB first.
//
// Ports:
//   clk, reset          system clock, synchronous active-high reset
//   in_data/valid/ready command byte stream (transfer on valid && ready)
//   reg_addr, reg_wdata register bus address and write value
//   reg_wr, reg_rd      one-cycle write / read strobes
//   reg_rdata           readback, valid RD_LATENCY cycles after reg_rd
//   out_data/valid/ready reply byte stream (transfer on valid && ready)
//   busy                high whenever not hunting for a frame start
//   frame_abort         one-cycle pulse when a partial frame is discarded

module fx2_reg_cmd_parser #(
    parameter int         RD_LATENCY = 1,
    parameter int         TIMEOUT    = 4096,
    parameter logic [7:0] SYNC_BYTE  = 8'hAA
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [15:0] reg_addr,
    output logic [31:0] reg_wdata,
    output logic        reg_wr,
    output logic        reg_rd,
    input  logic [31:0] reg_rdata,
    output logic [7:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        busy,
    output logic        frame_abort
);

    typedef enum logic [3:0] {
        S_HUNT, S_FLAG, S_A0, S_A1, S_V0, S_V1, S_V2, S_V3,
        S_WRITE, S_READ, S_WAIT, S_R0, S_R1, S_R2, S_R3
    } state_t;

    localparam int              IDLE_W   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(TIMEOUT);
    localparam logic [2:0]      LAT_MAX  = 3'(RD_LATENCY);

    state_t              state;
    state_t              state_next;
    logic                accept;
    logic                parsing;
    logic                timed_out;
    logic                abort_next;
    logic                wr_flag;
    logic [IDLE_W-1:0]   idle_cnt;
    logic [2:0]          lat_cnt;
    logic [31:0]         reply;

    assign accept  = in_valid && in_ready;
    assign parsing = (state >= S_FLAG) && (state <= S_V3);
    // A byte arriving on the cycle the count sits at TIMEOUT wins over the abort.
    assign timed_out = (TIMEOUT != 0) && parsing && !accept && (idle_cnt == IDLE_MAX);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_HUNT;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        abort_next = 1'b0;
        case (state)
            S_HUNT:  if (accept && in_data == SYNC_BYTE) state_next = S_FLAG;
            S_FLAG: begin
                if (accept) begin
                    if (in_data == 8'h00 || in_data == 8'h01) begin
                        state_next = S_A0;
                    end else begin
                        state_next = S_HUNT;
                        abort_next = 1'b1;
                    end
                end
            end
            S_A0:    if (accept) state_next = S_A1;
            S_A1:    if (accept) state_next = S_V0;
            S_V0:    if (accept) state_next = S_V1;
            S_V1:    if (accept) state_next = S_V2;
            S_V2:    if (accept) state_next = S_V3;
            S_V3:    if (accept) state_next = wr_flag ? S_WRITE : S_READ;
            S_WRITE: state_next = S_READ;
            S_READ:  state_next = S_WAIT;
            S_WAIT:  if (lat_cnt == LAT_MAX) state_next = S_R0;
            S_R0:    if (out_ready) state_next = S_R1;
            S_R1:    if (out_ready) state_next = S_R2;
            S_R2:    if (out_ready) state_next = S_R3;
            S_R3:    if (out_ready) state_next = S_HUNT;
            default: state_next = S_HUNT;
        endcase
        if (timed_out) begin
            state_next = S_HUNT;
            abort_next = 1'b1;
        end
    end

    always_comb begin
        in_ready  = 1'b0;
        reg_wr    = 1'b0;
        reg_rd    = 1'b0;
        out_valid = 1'b0;
        out_data  = 8'h00;
        busy      = 1'b1;
        case (state)
            S_HUNT: begin
                in_ready = 1'b1;
                busy     = 1'b0;
            end
            S_FLAG, S_A0, S_A1, S_V0, S_V1, S_V2, S_V3: in_ready = 1'b1;
            S_WRITE: reg_wr = 1'b1;
            S_READ:  reg_rd = 1'b1;
            S_R0: begin out_valid = 1'b1; out_data = reply[7:0];   end
            S_R1: begin out_valid = 1'b1; out_data = reply[15:8];  end
            S_R2: begin out_valid = 1'b1; out_data = reply[23:16]; end
            S_R3: begin out_valid = 1'b1; out_data = reply[31:24]; end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            reg_addr    <= 16'h0000;
            reg_wdata   <= 32'h0000_0000;
            wr_flag     <= 1'b0;
            idle_cnt    <= '0;
            lat_cnt     <= 3'd0;
            reply       <= 32'h0000_0000;
            frame_abort <= 1'b0;
        end else begin
            frame_abort <= abort_next;

            if (accept || !parsing || timed_out || TIMEOUT == 0) begin
                idle_cnt <= '0;
            end else begin
                idle_cnt <= idle_cnt + 1'b1;
            end

            if (accept) begin
                case (state)
                    S_FLAG:  wr_flag          <= in_data[0];
                    S_A0:    reg_addr[7:0]    <= in_data;
                    S_A1:    reg_addr[15:8]   <= in_data;
                    S_V0:    reg_wdata[7:0]   <= in_data;
                    S_V1:    reg_wdata[15:8]  <= in_data;
                    S_V2:    reg_wdata[23:16] <= in_data;
                    S_V3:    reg_wdata[31:24] <= in_data;
                    default: ;
                endcase
            end

            // lat_cnt = 1 in the first WAIT cycle, so the capture lands
            // exactly RD_LATENCY cycles after the reg_rd cycle.
            if (state == S_READ) begin
                lat_cnt <= 3'd1;
            end else if (state == S_WAIT) begin
                lat_cnt <= lat_cnt + 3'd1;
            end

            if (state == S_WAIT && lat_cnt == LAT_MAX) begin
                reply <= reg_rdata;
            end
        end
    end

endmodule
